// File: rtl/rx_core_pkg.sv
// Shared definitions for the ISO7816 UART receiver: FSM state encoding,
// default line levels and the byte parity helper.
package rx_core_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP1  = 3'd4,
      STOP2  = 3'd5
   } rxState_t;

   localparam logic START_BIT_DEFAULT = 1'b0;
   localparam logic STOP_BIT_DEFAULT  = 1'b1;

   // Even parity of a byte (1 when the byte holds an odd number of ones).
   function automatic logic parityOf(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit timer for the receiver: counts 0..clocksPerBit-1 and wraps, flags the
// mid-bit sample point and the last cycle of each bit.
module rx_bit_timer #(
   parameter int CPBW = 13
) (
   input  logic            clk,
   input  logic            nReset,
   input  logic            clear,
   input  logic [CPBW-1:0] clocksPerBit,
   output logic            samplePoint,
   output logic            bitEnd
);

   localparam logic [CPBW-1:0] ZERO = {CPBW{1'b0}};
   localparam logic [CPBW-1:0] ONE  = {{(CPBW-1){1'b0}}, 1'b1};

   logic [CPBW-1:0] count_r;

   // Decode the sample point and the bit end from the current count.
   always_comb begin
      samplePoint = (count_r == (clocksPerBit >> 1));
      bitEnd      = (count_r == (clocksPerBit - ONE));
   end

   // Bit-period counter: held at zero while cleared, wraps after the last cycle.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         count_r <= ZERO;
      end else if (clear) begin
         count_r <= ZERO;
      end else if (bitEnd) begin
         count_r <= ZERO;
      end else begin
         count_r <= count_r + ONE;
      end
   end

endmodule

// File: rtl/rx_core.sv
// ISO7816 UART receiver core: synchronises the serial line, frames one
// character (start, 8 data, parity, 1-2 stops), checks parity and stop bits,
// and hands each byte to the protocol layer over a ready/ack handshake.
module rx_core
   import rx_core_pkg::*;
#(
   parameter int   CLOCK_PER_BIT_WIDTH = 13,
   parameter logic START_BIT           = START_BIT_DEFAULT,
   parameter logic STOP_BIT            = STOP_BIT_DEFAULT
) (
   input  logic                           clk,
   input  logic                           nReset,
   input  logic                           serialIn,
   input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
   input  logic                           oddParity,
   input  logic                           msbFirst,
   input  logic                           stopBit2,
   input  logic                           ackDataOut,
   output logic [7:0]                     dataOut,
   output logic                           dataOutReady,
   output logic                           parityErr,
   output logic                           frameErr,
   output logic                           overrunErr,
   output logic                           run,
   output logic                           stopBits
);

   logic       sync1_r, sync2_r, hist_r;
   rxState_t   state_r, nextState_s;
   logic [2:0] bitCount_r, dataIndex_s;
   logic [7:0] shift_r;
   logic       cfgMsb_r, cfgOdd_r, cfgTwo_r;
   logic       perr_r, ferr_r, deliver_r;
   logic       startEdge_s, timerClear_s, samplePoint_s, bitEnd_s;
   logic       shiftEn_s, parityEn_s, stopSampleEn_s, frameDone_s, enterData_s;

   // Start edge: the line moves from idle level to the start level.
   // The timer runs from the detection cycle so the sample lands mid-bit.
   assign startEdge_s  = (hist_r == ~START_BIT) && (sync2_r == START_BIT);
   assign timerClear_s = (state_r == IDLE) && !startEdge_s;
   assign enterData_s  = (state_r == START) && (nextState_s == DATA);

   rx_bit_timer #(.CPBW(CLOCK_PER_BIT_WIDTH)) uTimer (
      .clk          (clk),
      .nReset       (nReset),
      .clear        (timerClear_s),
      .clocksPerBit (clocksPerBit),
      .samplePoint  (samplePoint_s),
      .bitEnd       (bitEnd_s)
   );

   // Two-flop synchroniser plus history flop, reset to the idle level.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         sync1_r <= ~START_BIT;
         sync2_r <= ~START_BIT;
         hist_r  <= ~START_BIT;
      end else begin
         sync1_r <= serialIn;
         sync2_r <= sync1_r;
         hist_r  <= sync2_r;
      end
   end

   // State register, with run/stopBits registered from the next state.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         state_r  <= IDLE;
         run      <= 1'b0;
         stopBits <= 1'b0;
      end else begin
         state_r  <= nextState_s;
         run      <= (nextState_s != IDLE);
         stopBits <= (nextState_s == STOP1) || (nextState_s == STOP2);
      end
   end

   // Next-state logic for the character framing.
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         IDLE: begin
            if (startEdge_s) nextState_s = START;
            else             nextState_s = IDLE;
         end
         START: begin
            if (samplePoint_s && (sync2_r != START_BIT)) nextState_s = IDLE;
            else if (bitEnd_s)                            nextState_s = DATA;
            else                                          nextState_s = START;
         end
         DATA: begin
            if (bitEnd_s && (bitCount_r == 3'd7)) nextState_s = PARITY;
            else                                  nextState_s = DATA;
         end
         PARITY: begin
            if (bitEnd_s) nextState_s = STOP1;
            else          nextState_s = PARITY;
         end
         STOP1: begin
            if (samplePoint_s && !cfgTwo_r) nextState_s = IDLE;
            else if (bitEnd_s && cfgTwo_r)  nextState_s = STOP2;
            else                            nextState_s = STOP1;
         end
         STOP2: begin
            if (samplePoint_s) nextState_s = IDLE;
            else               nextState_s = STOP2;
         end
         default: nextState_s = IDLE;
      endcase
   end

   // Per-state datapath strobes derived from the sample point.
   always_comb begin
      shiftEn_s      = 1'b0;
      parityEn_s     = 1'b0;
      stopSampleEn_s = 1'b0;
      frameDone_s    = 1'b0;
      case (state_r)
         DATA:   shiftEn_s  = samplePoint_s;
         PARITY: parityEn_s = samplePoint_s;
         STOP1: begin
            stopSampleEn_s = samplePoint_s;
            frameDone_s    = samplePoint_s & ~cfgTwo_r;
         end
         STOP2: begin
            stopSampleEn_s = samplePoint_s;
            frameDone_s    = samplePoint_s;
         end
         default: begin
            shiftEn_s   = 1'b0;
            frameDone_s = 1'b0;
         end
      endcase
   end

   // Data bit position for the current bit, reversed for MSB-first characters.
   always_comb begin
      if (cfgMsb_r) dataIndex_s = 3'd7 - bitCount_r;
      else          dataIndex_s = bitCount_r;
   end

   // Character datapath: config capture, shift register, parity and stop checks.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         cfgMsb_r   <= 1'b0;
         cfgOdd_r   <= 1'b0;
         cfgTwo_r   <= 1'b0;
         bitCount_r <= 3'd0;
         shift_r    <= 8'h00;
         perr_r     <= 1'b0;
         ferr_r     <= 1'b0;
         deliver_r  <= 1'b0;
      end else begin
         if (enterData_s) begin
            cfgMsb_r   <= msbFirst;
            cfgOdd_r   <= oddParity;
            cfgTwo_r   <= stopBit2;
            bitCount_r <= 3'd0;
         end else if ((state_r == DATA) && bitEnd_s) begin
            bitCount_r <= bitCount_r + 3'd1;
         end
         if (shiftEn_s) shift_r[dataIndex_s] <= sync2_r;
         if (parityEn_s) perr_r <= parityOf(shift_r) ^ sync2_r ^ cfgOdd_r;
         if (stopSampleEn_s) begin
            ferr_r <= ((state_r == STOP2) ? ferr_r : 1'b0) | (sync2_r != STOP_BIT);
         end
         deliver_r <= frameDone_s;
      end
   end

   // Consumer handshake: a delivery beats a simultaneous ack; a delivery
   // into a full holding register is dropped and flagged as overrun.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         dataOut      <= 8'h00;
         dataOutReady <= 1'b0;
         parityErr    <= 1'b0;
         frameErr     <= 1'b0;
         overrunErr   <= 1'b0;
      end else if (deliver_r && (!dataOutReady || ackDataOut)) begin
         dataOut      <= shift_r;
         parityErr    <= perr_r;
         frameErr     <= ferr_r;
         dataOutReady <= 1'b1;
         overrunErr   <= overrunErr & ~ackDataOut;
      end else if (deliver_r) begin
         overrunErr   <= 1'b1;
      end else if (ackDataOut) begin
         dataOutReady <= 1'b0;
         overrunErr   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rx_core.sv
// Self-checking bench for rx_core: directed characters with a frame-level
// timing model and hand-computed literal expectations.
module tb_rx_core;

   logic        clk = 1'b0, nReset = 1'b0, serialIn = 1'b1;
   logic [12:0] clocksPerBit = 13'd372;
   logic        oddParity = 1'b0, msbFirst = 1'b0, stopBit2 = 1'b0, ackDataOut = 1'b0;
   logic [7:0]  dataOut;
   logic        dataOutReady, parityErr, frameErr, overrunErr, run, stopBits;

   rx_core dut (
      .clk(clk), .nReset(nReset), .serialIn(serialIn), .clocksPerBit(clocksPerBit),
      .oddParity(oddParity), .msbFirst(msbFirst), .stopBit2(stopBit2),
      .ackDataOut(ackDataOut), .dataOut(dataOut), .dataOutReady(dataOutReady),
      .parityErr(parityErr), .frameErr(frameErr), .overrunErr(overrunErr),
      .run(run), .stopBits(stopBits)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic rstSeen, ackSeen;
   int   nVectors = 0, nMiscompares = 0;

   // Edge counter and the reset/ack values each edge saw.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rstSeen <= nReset;
      ackSeen <= ackDataOut;
   end

   typedef struct {
      int         c0;
      int         cpb;
      bit         glitch;
      bit         two;
      logic [7:0] b;
      bit         perr;
      bit         ferr;
   } frame_t;

   frame_t     fq[$];
   bit         modelValid = 1'b0;
   logic [7:0] mData = 8'h00;
   bit         mReady = 1'b0, mPerr = 1'b0, mFerr = 1'b0, mOverrun = 1'b0, mRun = 1'b0, mStop = 1'b0;

   // Frame-level model: a character whose start bit is driven after edge c0 is busy
   // from edge c0+3 until its last stop sample at c0+3+cpb/2+lastBit*cpb, and is
   // delivered one edge later. Outputs are compared on every cycle after reset.
   always @(negedge clk) begin : modelCompare
      int         e, h, endEdge;
      frame_t     keep[$];
      bit         dlv;
      logic [7:0] db;
      bit         dp, df;
      e = cyc;
      if (rstSeen !== 1'b1) begin
         modelValid = 1'b1;
         mData = 8'h00; mReady = 0; mPerr = 0; mFerr = 0; mOverrun = 0; mRun = 0; mStop = 0;
         fq.delete();
      end else if (modelValid) begin
         dlv = 0; db = 8'h00; dp = 0; df = 0;
         mRun = 0; mStop = 0;
         keep.delete();
         foreach (fq[i]) begin
            h = fq[i].cpb / 2;
            endEdge = fq[i].glitch ? fq[i].c0 + 3 + h
                                   : fq[i].c0 + 3 + h + (fq[i].two ? 11 : 10) * fq[i].cpb;
            if (e >= fq[i].c0 + 3 && e < endEdge) mRun = 1;
            if (!fq[i].glitch && e >= fq[i].c0 + 2 + 10 * fq[i].cpb && e < endEdge) mStop = 1;
            if (!fq[i].glitch && e == endEdge + 1) begin
               dlv = 1; db = fq[i].b; dp = fq[i].perr; df = fq[i].ferr;
            end
            if (e < endEdge + 1) keep.push_back(fq[i]);
         end
         fq = keep;
         if (dlv && mReady && !ackSeen) begin
            mOverrun = 1;
         end else if (dlv) begin
            mData = db; mPerr = dp; mFerr = df; mReady = 1;
            if (ackSeen) mOverrun = 0;
         end else if (ackSeen) begin
            mReady = 0; mOverrun = 0;
         end
      end
      if (modelValid) begin
         nVectors++;
         if (dataOut !== mData || dataOutReady !== mReady || parityErr !== mPerr ||
             frameErr !== mFerr || overrunErr !== mOverrun || run !== mRun || stopBits !== mStop) begin
            nMiscompares++;
            $display("FAIL cycle %0d outputs: got data=%h rdy=%b perr=%b ferr=%b ovr=%b run=%b stop=%b, need data=%h rdy=%b perr=%b ferr=%b ovr=%b run=%b stop=%b",
                     e, dataOut, dataOutReady, parityErr, frameErr, overrunErr, run, stopBits,
                     mData, mReady, mPerr, mFerr, mOverrun, mRun, mStop);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("FAIL %s: got %h, need %h", name, act, exp);
      end
   endtask

   task automatic ackPulse();
      ackDataOut = 1'b1;
      tick();
      ackDataOut = 1'b0;
      tick();
   endtask

   // Drive one character from the current (post-edge) time; stops early
   // before bit abortAfter (0 = start bit) when abortAfter is within the frame.
   task automatic sendFrame(input logic [7:0] b, input logic par, input logic s1,
                            input logic s2, input int abortAfter);
      logic   bits[12];
      int     n, cpbI;
      frame_t f;
      cpbI = int'(clocksPerBit);
      n = stopBit2 ? 12 : 11;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = msbFirst ? b[7 - i] : b[i];
      bits[9] = par; bits[10] = s1; bits[11] = s2;
      f.c0 = cyc; f.cpb = cpbI; f.glitch = 0; f.two = stopBit2; f.b = b;
      f.perr = ((($countones(b) + int'(par)) % 2) != int'(oddParity));
      f.ferr = (s1 !== 1'b1) || (stopBit2 && (s2 !== 1'b1));
      fq.push_back(f);
      for (int j = 0; j < n; j++) begin
         if (j == abortAfter) return;
         serialIn = bits[j];
         repeat (cpbI) @(posedge clk);
         #1;
      end
      serialIn = 1'b1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: time limit reached, got no finish, need finish");
      $fatal(1);
   end

   initial begin : stimulus
      int     runCnt, dEdge;
      frame_t g;
      nReset = 1'b0;
      repeat (3) tick();
      checkVal("reset_data", dataOut, 8'h00);
      checkVal("reset_ready", {7'd0, dataOutReady}, 8'h00);
      checkVal("reset_run", {7'd0, run}, 8'h00);
      nReset = 1'b1;
      tick();

      // T1: 0x3B, even parity bit 1, LSB first, 372 clocks per bit
      clocksPerBit = 13'd372; oddParity = 1'b0; msbFirst = 1'b0; stopBit2 = 1'b0;
      sendFrame(8'h3B, 1'b1, 1'b1, 1'b1, 99);
      repeat (8) tick();
      checkVal("t1_data", dataOut, 8'h3B);
      checkVal("t1_ready", {7'd0, dataOutReady}, 8'h01);
      checkVal("t1_perr", {7'd0, parityErr}, 8'h00);
      checkVal("t1_ferr", {7'd0, frameErr}, 8'h00);
      ackPulse();
      checkVal("t1_ack_ready", {7'd0, dataOutReady}, 8'h00);

      // T2: same byte with wrong parity bit
      sendFrame(8'h3B, 1'b0, 1'b1, 1'b1, 99);
      repeat (8) tick();
      checkVal("t2_data", dataOut, 8'h3B);
      checkVal("t2_perr", {7'd0, parityErr}, 8'h01);
      ackPulse();

      // T3: MSB first, odd parity, 16 clocks per bit
      clocksPerBit = 13'd16; msbFirst = 1'b1; oddParity = 1'b1;
      sendFrame(8'h3F, 1'b1, 1'b1, 1'b1, 99);
      repeat (8) tick();
      checkVal("t3_data", dataOut, 8'h3F);
      checkVal("t3_perr", {7'd0, parityErr}, 8'h00);
      ackPulse();
      msbFirst = 1'b0; oddParity = 1'b0;

      // T4: 3-clock low glitch on an idle line
      g.c0 = cyc; g.cpb = 16; g.glitch = 1; g.two = 0; g.b = 8'h00; g.perr = 0; g.ferr = 0;
      fq.push_back(g);
      serialIn = 1'b0;
      repeat (3) tick();
      serialIn = 1'b1;
      runCnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (run === 1'b1) runCnt++;
      end
      checkVal("t4_run_len_ok", {7'd0, (runCnt >= 1 && runCnt <= 8)}, 8'h01);
      checkVal("t4_ready", {7'd0, dataOutReady}, 8'h00);
      tick();

      // T5: back-to-back 0x55 then 0xAA without ack
      sendFrame(8'h55, 1'b0, 1'b1, 1'b1, 99);
      sendFrame(8'hAA, 1'b0, 1'b1, 1'b1, 99);
      repeat (8) tick();
      checkVal("t5_data", dataOut, 8'h55);
      checkVal("t5_overrun", {7'd0, overrunErr}, 8'h01);
      ackPulse();
      checkVal("t5_ack_ready", {7'd0, dataOutReady}, 8'h00);
      checkVal("t5_ack_overrun", {7'd0, overrunErr}, 8'h00);

      // T7: ack coinciding with a delivery into a full register
      sendFrame(8'h12, 1'b0, 1'b1, 1'b1, 99);
      repeat (8) tick();
      dEdge = cyc + 3 + 8 + 10 * 16 + 1;
      fork
         sendFrame(8'h34, 1'b1, 1'b1, 1'b1, 99);
         begin
            repeat (dEdge - 1 - cyc) @(posedge clk);
            #1;
            ackDataOut = 1'b1;
            tick();
            ackDataOut = 1'b0;
         end
      join
      repeat (8) tick();
      checkVal("t7_data", dataOut, 8'h34);
      checkVal("t7_ready", {7'd0, dataOutReady}, 8'h01);
      checkVal("t7_overrun", {7'd0, overrunErr}, 8'h00);
      ackPulse();

      // T6: two stop bits with the second one low, then reset mid-DATA
      stopBit2 = 1'b1;
      sendFrame(8'hA5, 1'b0, 1'b1, 1'b0, 99);
      repeat (8) tick();
      checkVal("t6_data", dataOut, 8'hA5);
      checkVal("t6_ferr", {7'd0, frameErr}, 8'h01);
      checkVal("t6_perr", {7'd0, parityErr}, 8'h00);
      sendFrame(8'h5A, 1'b0, 1'b1, 1'b1, 4);
      checkVal("t6_run_mid", {7'd0, run}, 8'h01);
      nReset = 1'b0;
      serialIn = 1'b1;
      tick();
      checkVal("t6_rst_data", dataOut, 8'h00);
      checkVal("t6_rst_flags", {3'd0, dataOutReady, parityErr, frameErr, overrunErr, run}, 8'h00);
      nReset = 1'b1;
      stopBit2 = 1'b0;
      repeat (2) tick();

      // Shortest legal bit period
      clocksPerBit = 13'd4;
      sendFrame(8'hC3, 1'b0, 1'b1, 1'b1, 99);
      repeat (8) tick();
      checkVal("cpb4_data", dataOut, 8'hC3);
      checkVal("cpb4_ready", {7'd0, dataOutReady}, 8'h01);
      checkVal("cpb4_perr", {7'd0, parityErr}, 8'h00);
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
